// File: rtl/debounce_scan_ctrl.sv
// Multi-channel button debouncer: one shared update engine serviced round-robin,
// producing clean levels plus a press/release/long-press event stream.
module debounce_scan_ctrl #(
    parameter int N_CH       = 4,
    parameter int PRESC      = 4,
    parameter int THRESH     = 4,
    parameter int LONG_TICKS = 8,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_CH-1:0] noisy_in,
    output logic [N_CH-1:0] clean_out,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [CH_W-1:0] ev_ch,
    output logic [1:0]      ev_type,
    output logic            overflow
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int CW = (THRESH > 1) ? $clog2(THRESH + 1) : 1;
    localparam int LW = (LONG_TICKS > 1) ? $clog2(LONG_TICKS + 1) : 1;

    localparam logic [PW-1:0]   PSC_LAST  = PW'(PRESC - 1);
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(N_CH - 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(THRESH - 1);
    localparam logic [LW-1:0]   LONG_LAST = LW'(LONG_TICKS);

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;
    localparam logic [1:0] EV_LONG    = 2'b11;

    logic [N_CH-1:0] sync1_q, sync2_q;
    logic [N_CH-1:0] clean_q;
    logic [N_CH-1:0] ldone_q;
    logic [CW-1:0]   cnt_q  [N_CH];
    logic [LW-1:0]   long_q [N_CH];
    logic [PW-1:0]   psc_q;
    logic [CH_W-1:0] idx_q;

    logic            ev_valid_q;
    logic [CH_W-1:0] ev_ch_q;
    logic [1:0]      ev_type_q;
    logic            ovf_q;

    logic            strobe;
    logic            s_bit, q_bit, cur_ldone;
    logic [CW-1:0]   cur_cnt;
    logic [LW-1:0]   cur_long;
    logic            clean_d, ldone_d;
    logic [CW-1:0]   cnt_d;
    logic [LW-1:0]   long_d;
    logic            gen;
    logic [1:0]      gen_type;
    logic            fire, drain;

    assign strobe    = en && (psc_q == PSC_LAST);
    assign s_bit     = sync2_q[idx_q];
    assign q_bit     = clean_q[idx_q];
    assign cur_cnt   = cnt_q[idx_q];
    assign cur_long  = long_q[idx_q];
    assign cur_ldone = ldone_q[idx_q];

    // Shared engine: next state of whichever channel the scan index selects.
    always_comb begin
        clean_d  = q_bit;
        cnt_d    = cur_cnt;
        long_d   = cur_long;
        ldone_d  = cur_ldone;
        gen      = 1'b0;
        gen_type = 2'b00;
        if (s_bit != q_bit) begin
            if (cur_cnt == CNT_LAST) begin
                clean_d  = s_bit;
                cnt_d    = '0;
                gen      = 1'b1;
                gen_type = s_bit ? EV_PRESS : EV_RELEASE;
                if (!s_bit) begin
                    long_d  = '0;
                    ldone_d = 1'b0;
                end
            end else begin
                cnt_d = cur_cnt + CW'(1);
            end
        end else begin
            cnt_d = '0;
            if (s_bit && !cur_ldone) begin
                long_d = cur_long + LW'(1);
                if (long_d == LONG_LAST) begin
                    gen      = 1'b1;
                    gen_type = EV_LONG;
                    ldone_d  = 1'b1;
                end
            end
        end
    end

    assign fire  = strobe && gen;
    assign drain = ev_valid_q && ev_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            clean_q    <= '0;
            ldone_q    <= '0;
            psc_q      <= '0;
            idx_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_ch_q    <= '0;
            ev_type_q  <= 2'b00;
            ovf_q      <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= '0;
                long_q[i] <= '0;
            end
        end else begin
            sync1_q <= noisy_in;
            sync2_q <= sync1_q;
            if (en) begin
                psc_q <= strobe ? '0 : psc_q + PW'(1);
            end
            if (strobe) begin
                idx_q          <= (idx_q == CH_LAST) ? '0 : idx_q + CH_W'(1);
                clean_q[idx_q] <= clean_d;
                cnt_q[idx_q]   <= cnt_d;
                long_q[idx_q]  <= long_d;
                ldone_q[idx_q] <= ldone_d;
            end
            // Single-entry event register: a full, non-draining register drops the new event.
            if (fire) begin
                if (!ev_valid_q || drain) begin
                    ev_valid_q <= 1'b1;
                    ev_ch_q    <= idx_q;
                    ev_type_q  <= gen_type;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else if (drain) begin
                ev_valid_q <= 1'b0;
            end
        end
    end

    assign clean_out = clean_q;
    assign ev_valid  = ev_valid_q;
    assign ev_ch     = ev_ch_q;
    assign ev_type   = ev_type_q;
    assign overflow  = ovf_q;

endmodule
